// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared decode constants and enums for the EX-stage multiply/divide unit
package muldiv_pkg;
  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] FUNCT_MFHI   = 6'h10;
  localparam logic [5:0] FUNCT_MTHI   = 6'h11;
  localparam logic [5:0] FUNCT_MFLO   = 6'h12;
  localparam logic [5:0] FUNCT_MTLO   = 6'h13;
  localparam logic [5:0] FUNCT_MULT   = 6'h18;
  localparam logic [5:0] FUNCT_MULTU  = 6'h19;
  localparam logic [5:0] FUNCT_DIV    = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU   = 6'h1B;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_t;
  typedef enum logic {OP_MUL, OP_DIV} muldiv_op_t;
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: shift-add multiply / restoring divide datapath, one bit per step
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  muldiv_op_t        op_in,
  input  logic              sgn,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output muldiv_op_t        op,
  output logic [2*XLEN-1:0] acc,
  output logic              last
);
  logic [XLEN-1:0]  mag_a, mag_b, opb, diff;
  logic [XLEN:0]    sum, t;
  logic             ge;
  logic [CNT_W-1:0] cnt;
  logic [2*XLEN-1:0] nxt;
  // acc holds {upper, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    mag_a = (sgn && a[XLEN-1]) ? -a : a;
    mag_b = (sgn && b[XLEN-1]) ? -b : b;
    sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    t     = acc[2*XLEN-1:XLEN-1];
    ge    = t >= {1'b0, opb};
    diff  = t[XLEN-1:0] - opb;
    nxt   = (op == OP_MUL) ? {sum, acc[XLEN-1:1]}
                           : {ge ? diff : t[XLEN-1:0], acc[XLEN-2:0], ge};
    last  = cnt == CNT_W'(XLEN - 1);
  end
  // load operand magnitudes, then advance one iteration per step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      opb <= '0;
      op  <= OP_MUL;
      cnt <= '0;
    end else if (load) begin
      acc <= {{XLEN{1'b0}}, mag_a};
      opb <= mag_b;
      op  <= op_in;
      cnt <= '0;
    end else if (step) begin
      acc <= nxt;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/DIV unit with HI/LO registers and pipeline stall control
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_sel_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);
  muldiv_state_t     state, nxt_state;
  muldiv_op_t        op;
  logic [5:0]        funct;
  logic              rtype, is_md, is_mf, do_load, last;
  logic              neg_q, neg_r, div_zero;
  logic [XLEN-1:0]   raw, q, r;
  logic [2*XLEN-1:0] acc, prod;
  logic              unused_inst;
  assign unused_inst = ^inst_i[25:6];
  muldiv_iter_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (do_load),
    .step  (state == BUSY),
    .op_in (funct[1] ? OP_DIV : OP_MUL),
    .sgn   (~funct[0]),
    .a     (data1_i),
    .b     (data2_i),
    .op    (op),
    .acc   (acc),
    .last  (last)
  );
  // decode, next state, stall, MF* result and sign-corrected results
  always_comb begin
    funct        = inst_i[5:0];
    rtype        = inst_i[31:26] == OPCODE_RTYPE;
    is_md        = rtype && funct inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    is_mf        = rtype && (funct == FUNCT_MFHI || funct == FUNCT_MFLO);
    do_load      = state == IDLE && is_md;
    nxt_state    = (state == IDLE) ? (is_md ? BUSY : IDLE)
                 : (state == BUSY) ? (last ? DONE : BUSY) : IDLE;
    stall_o      = do_load || state == BUSY;
    result_sel_o = is_mf;
    result_o     = !is_mf ? '0 : (funct == FUNCT_MFHI) ? hi_o : lo_o;
    prod         = neg_q ? -acc : acc;
    q            = div_zero ? '1 : neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    r            = div_zero ? raw : neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  end
  // state register; busy covers BUSY and DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_o <= 1'b0;
    end else begin
      state  <= nxt_state;
      busy_o <= nxt_state != IDLE;
    end
  end
  // capture result signs and the raw dividend when an operation starts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      raw      <= '0;
    end else if (do_load) begin
      neg_q    <= ~funct[0] && (data1_i[XLEN-1] ^ data2_i[XLEN-1]);
      neg_r    <= ~funct[0] && data1_i[XLEN-1];
      div_zero <= funct[1] && data2_i == '0;
      raw      <= data1_i;
    end
  end
  // HI/LO update on completion or on MTHI/MTLO while idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (state == DONE) begin
      {hi_o, lo_o} <= (op == OP_MUL) ? prod : {r, q};
    end else if (state == IDLE && rtype && funct == FUNCT_MTHI) begin
      hi_o <= data1_i;
    end else if (state == IDLE && rtype && funct == FUNCT_MTLO) begin
      lo_o <= data1_i;
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed self-checking bench for ex_muldiv
module tb_ex_muldiv;
  import muldiv_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_i = '0, data1_i = '0, data2_i = '0;
  logic        stall_o, busy_o, result_sel_o;
  logic [31:0] result_o, hi_o, lo_o;
  int passed = 0, failed = 0, total = 0, n = 0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_i       (inst_i),
    .data1_i      (data1_i),
    .data2_i      (data2_i),
    .stall_o      (stall_o),
    .busy_o       (busy_o),
    .result_o     (result_o),
    .result_sel_o (result_sel_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  function automatic logic [31:0] rt(input logic [5:0] f);
    return {26'b0, f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_stall();
    n = 0;
    while (stall_o === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic run_chk(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    inst_i = rt(f); data1_i = a; data2_i = b;
    #1;
    count_stall();
    chk({tag, " stall_cycles"}, n, 33);
    chk({tag, " done_stall"}, {31'b0, stall_o}, 0);
    chk({tag, " done_busy"}, {31'b0, busy_o}, 1);
    tick();
    inst_i = '0;
    #1;
    chk({tag, " hi"}, hi_o, ehi);
    chk({tag, " lo"}, lo_o, elo);
    chk({tag, " idle_busy"}, {31'b0, busy_o}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    tick(); tick();
    #1;
    chk("reset hi", hi_o, 0);
    chk("reset lo", lo_o, 0);
    chk("reset busy", {31'b0, busy_o}, 0);
    chk("reset stall", {31'b0, stall_o}, 0);
    chk("reset sel", {31'b0, result_sel_o}, 0);
    rst_n = 1'b1;
    tick();

    run_chk("multu_max", FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    inst_i = rt(FUNCT_MFHI);
    #1;
    chk("mfhi result", result_o, 32'hFFFFFFFE);
    chk("mfhi sel", {31'b0, result_sel_o}, 1);
    chk("mfhi stall", {31'b0, stall_o}, 0);
    tick();
    inst_i = rt(FUNCT_MFLO);
    #1;
    chk("mflo result", result_o, 32'h00000001);
    tick();

    run_chk("mult_neg", FUNCT_MULT, -32'sd7, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_chk("div_neg", FUNCT_DIV, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_chk("divu_zero", FUNCT_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
    run_chk("div_zero_neg", FUNCT_DIV, -32'sd5, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_chk("div_ovf", FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_chk("divu_big", FUNCT_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF);

    inst_i = rt(FUNCT_MTHI); data1_i = 32'h1234;
    #1;
    chk("mthi stall", {31'b0, stall_o}, 0);
    tick();
    inst_i = rt(FUNCT_MFHI); data1_i = '0;
    #1;
    chk("mthi hi", hi_o, 32'h1234);
    chk("mfhi after mthi", result_o, 32'h1234);
    chk("mfhi after mthi stall", {31'b0, stall_o}, 0);
    tick();
    inst_i = rt(FUNCT_MTLO); data1_i = 32'h5678;
    #1;
    chk("mtlo stall", {31'b0, stall_o}, 0);
    tick();
    inst_i = rt(FUNCT_MFLO); data1_i = '0;
    #1;
    chk("mflo after mtlo", result_o, 32'h5678);
    chk("mtlo hi kept", hi_o, 32'h1234);
    tick();

    inst_i = rt(FUNCT_MULT); data1_i = 32'd6; data2_i = 32'd7;
    #1;
    count_stall();
    chk("b2b mult stall_cycles", n, 33);
    chk("b2b done_stall", {31'b0, stall_o}, 0);
    tick();
    inst_i = rt(FUNCT_DIV); data1_i = 32'd100; data2_i = 32'd7;
    #1;
    chk("b2b mult hi", hi_o, 0);
    chk("b2b mult lo", lo_o, 32'd42);
    chk("b2b div start stall", {31'b0, stall_o}, 1);
    count_stall();
    chk("b2b div stall_cycles", n, 33);
    tick();
    inst_i = '0;
    #1;
    chk("b2b div hi", hi_o, 32'd2);
    chk("b2b div lo", lo_o, 32'd14);
    tick();

    inst_i = rt(FUNCT_MULTU); data1_i = 32'd6; data2_i = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    chk("midop busy", {31'b0, busy_o}, 1);
    rst_n = 1'b0; inst_i = '0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst busy", {31'b0, busy_o}, 0);
    chk("midrst hi", hi_o, 0);
    chk("midrst lo", lo_o, 0);
    chk("midrst stall", {31'b0, stall_o}, 0);
    tick();
    chk("midrst stays idle", {31'b0, busy_o}, 0);
    run_chk("after_rst", FUNCT_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage. Consumes the instruction word and operands presented by the ID/EX pipeline register. Drives the reverse-direction `stall_o` that freezes the PC, IF/ID and ID/EX while a MULT/DIV runs. Owns the architectural HI/LO registers and returns them to the EX result path for MFHI/MFLO.

## Interface

Parameters:
- `XLEN`, default 32: operand and HI/LO width.
- `CNT_W`, default 6: iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `inst_i`  in  32  instruction word currently held in ID/EX (`inst_o` of ID/EX).
- `data1_i`  in  XLEN  rs operand from ID/EX.
- `data2_i`  in  XLEN  rt operand from ID/EX.
- `stall_o`  out  1  hold request to PC, IF/ID and ID/EX; combinational.
- `busy_o`  out  1  high while state is BUSY or DONE; registered.
- `result_o`  out  XLEN  HI for MFHI, LO for MFLO, else 0; combinational.
- `result_sel_o`  out  1  high when `inst_i` is MFHI/MFLO; EX result mux selects `result_o`.
- `hi_o`, `lo_o`  out  XLEN  current HI/LO register values.

## Operation

- Decode on opcode 0 with funct: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13. Any other word, including the all-zero bubble, is ignored.
- FSM states: IDLE, BUSY, DONE.
- **IDLE, MULT/DIV decoded:**
  - Latch the operand magnitudes. Signed ops take two's-complement absolute values; unsigned ops pass operands through.
  - Latch result signs: product sign = sign1 XOR sign2; quotient sign = sign1 XOR sign2; remainder sign = sign1.
  - Clear the accumulator, set cnt = 0, go to BUSY.
- **BUSY:** one iteration per cycle, cnt increments. Go to DONE when cnt == XLEN-1.
  - Multiply: shift-add over a 2·XLEN accumulator, one multiplier bit (LSB first) per cycle.
  - Divide: restoring division, one quotient bit (MSB first) per cycle.
- **DONE:**
  - Apply sign fixup.
  - Multiply: {HI,LO} = product.
  - Divide: LO = quotient, HI = remainder.
  - Go to IDLE.
- **Divide by zero** (divisor latched as 0): result is LO = all-ones, HI = dividend (raw `data1_i`), signed or unsigned. Still takes full latency.
- **Signed overflow** DIV 0x80000000 / -1: LO = 0x80000000, HI = 0.
- **MTHI/MTLO in IDLE:** write `data1_i` to HI/LO at the cycle's edge; no stall.
- **MFHI/MFLO in IDLE:** `result_o` is the current register, no stall. HI/LO written in DONE are visible to the next instruction.
- `stall_o` = (IDLE and MULT/DIV decoded) or BUSY. It is low in DONE, so ID/EX advances at the end of DONE. A MULT/DIV still on `inst_i` during DONE therefore does not restart.
- **Reset (`rst_n` low at an edge), any state including mid-operation:** state → IDLE, HI = LO = 0, cnt = 0, busy_o = 0. The in-flight op is discarded.

## Timing

- Cycle 0: MULT/DIV in EX, IDLE, stall_o = 1.
- Cycles 1..XLEN: BUSY, stall_o = 1.
- Cycle XLEN+1: DONE, stall_o = 0.
- Total stall is XLEN+1 cycles (33 at default). HI/LO update at the end of cycle XLEN+1. The following instruction enters EX in cycle XLEN+2.
- `busy_o` is high in cycles 1..XLEN+1.
- Back-to-back MULT/DIV: the second starts in its own cycle 0, directly after DONE, with no gap.
- Reset values of all registered outputs are 0. `stall_o` and `result_sel_o` follow `inst_i` combinationally, and are 0 during reset only if `inst_i` is a bubble.

## Structure

- Shared package `muldiv_pkg`:
  - funct constants (FUNCT_MULT … FUNCT_MTLO), OPCODE_RTYPE
  - state enum `muldiv_state_t` {IDLE, BUSY, DONE}
  - op enum {OP_MUL, OP_DIV}
- Sub-module `muldiv_iter_core`: accumulator/shift datapath and counter, driven by load/step/op/signed controls. `ex_muldiv` keeps the decode, FSM, sign fixup, HI/LO registers and stall logic.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF → stall_o high exactly 33 cycles; HI = 0xFFFFFFFE, LO = 0x00000001; following MFHI gives 0xFFFFFFFE.
- MULT −7 × 3 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 0 → LO = 0xFFFFFFFF, HI = 100 after 33 stall cycles; DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- MTHI 0x1234 then MFHI → no stall; result_o = 0x1234 in the MFHI cycle; MTLO/MFLO likewise.
- Back-to-back MULT, DIV → two 33-cycle stall windows separated by exactly one DONE cycle with stall_o = 0; both HI/LO results correct.
- rst_n low in BUSY cycle 10 → next edge: IDLE, busy_o = 0, HI = LO = 0; with a bubble on inst_i, stall_o = 0.
